serv_ext_arbiter: RTL
=====================

# serv_ext_arbiter

Sequences the SERV extension port between two coprocessors: the multiply/divide unit (MDU) and the AVA accelerator. It sits between the core's extension interface and the two units. It latches rs1/rs2/funct3 when a request is accepted and drives exactly one unit at a time. It returns that unit's 32-bit result to the core as a single-cycle ready pulse, with a watchdog that completes hung requests with a zero result and an error flag.

## Interface
- TIMEOUT, 64: busy cycles allowed before forced completion; 0 disables the watchdog.
- clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_mdu_valid  in  1  core MDU request; level, held until o_ext_ready.
- i_ava_valid  in  1  core AVA request; level, held until o_ext_ready.
- i_ext_rs1  in  32  core operand 1.
- i_ext_rs2  in  32  core operand 2.
- i_ext_funct3  in  3  core funct3.
- o_ext_ready  out  1  one-cycle completion pulse to core.
- o_ext_rd  out  32  result; valid while o_ext_ready=1.
- o_unit_rs1  out  32  latched operand 1, shared by both units.
- o_unit_rs2  out  32  latched operand 2, shared by both units.
- o_unit_funct3  out  3  latched funct3, shared by both units.
- o_mdu_valid  out  1  MDU request level.
- i_mdu_ready  in  1  MDU done pulse.
- i_mdu_rd  in  32  MDU result.
- o_ava_valid  out  1  AVA request level.
- i_ava_ready  in  1  AVA done pulse.
- i_ava_rd  in  32  AVA result.
- o_err  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States:
  - IDLE.
  - BUSY_MDU.
  - BUSY_AVA.
  - RESP.
  - DRAIN.
- IDLE:
  - i_mdu_valid=1: latch operands and funct3, go to BUSY_MDU.
  - Otherwise, i_ava_valid=1: latch operands and funct3, go to BUSY_AVA.
  - Both valid: MDU wins, AVA is ignored.
- BUSY_x:
  - o_x_valid=1, and the latched operands are held stable.
  - On i_x_ready=1: capture i_x_rd into the result register, clear o_x_valid, go to RESP.
  - The other unit's ready is ignored.
- Watchdog:
  - Counter clears on entry to BUSY_x and increments each BUSY cycle.
  - When the counter reaches TIMEOUT without ready: result=0, set the error flag, go to RESP.
  - If ready and expiry coincide, ready wins; no error.
- RESP:
  - o_ext_ready=1 and o_ext_rd=result for exactly one cycle.
  - o_err=1 in this cycle if the error flag is set.
  - Then go to DRAIN.
- DRAIN:
  - One cycle; core valid inputs are ignored because the core drops valid during this cycle.
  - Then go to IDLE.
- o_ext_rd is 0 whenever o_ext_ready=0.
- Reset:
  - Synchronous, any state → IDLE.
  - All outputs reset to 0; the result register, counter and error flag clear.
  - A unit mid-operation sees its valid drop; a late ready from it while in IDLE is ignored.

## Timing
- Core valid sampled at cycle t → o_x_valid=1 and operands valid from t+1.
- Unit ready at cycle r (r ≥ t+1) → o_ext_ready at r+1.
- Minimum request-to-completion: 2 cycles.
- Next request can be accepted no earlier than r+3 (after RESP, DRAIN, IDLE).
- Watchdog: o_ext_ready/o_err at t+1+TIMEOUT+1 when no ready arrives.
- o_ext_ready, o_err, o_ext_rd, the o_*_valid outputs and the o_unit_* outputs are all registered outputs.

## Structure
- Package serv_ext_pkg holds:
  - State encoding (IDLE, BUSY_MDU, BUSY_AVA, RESP, DRAIN; 3 bits).
  - Unit ID constants.
- Sub-module serv_ext_watchdog, parameterised on TIMEOUT:
  - Counter width $clog2(TIMEOUT+1).
  - Inputs clr and en; output expired.
  - Ties expired to 0 when TIMEOUT=0.

## Test plan
- MDU request, rs1=7, rs2=6, funct3=0; MDU ready 3 cycles after o_mdu_valid with rd=42 → o_unit_rs1/rs2/funct3=7/6/0 while busy; o_ext_ready one cycle with o_ext_rd=42, o_err=0, o_ava_valid stays 0.
- AVA request; AVA ready in the same cycle o_ava_valid rises, rd=0xDEADBEEF → o_ext_ready exactly 2 cycles after core valid, o_ext_rd=0xDEADBEEF.
- i_mdu_valid and i_ava_valid raised together → only o_mdu_valid asserts; a stray i_ava_ready=1 during BUSY_MDU is ignored.
- TIMEOUT=4, MDU never ready → o_mdu_valid drops after 4 busy cycles; o_ext_ready=1, o_ext_rd=0, o_err=1 for one cycle.
- i_rst asserted in BUSY_AVA → next cycle all outputs 0 and state IDLE; an i_ava_ready pulse after reset produces no o_ext_ready.
- Back-to-back requests: core reasserts valid in DRAIN then holds it → request ignored in DRAIN, accepted in IDLE; second result returned correctly.

Source files
------------

// File: rtl/serv_ext_pkg.sv
// Shared encodings for the SERV extension-port arbiter: FSM states and unit IDs.
package serv_ext_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_BUSY_MDU = 3'd1;
   localparam logic [2:0] ST_BUSY_AVA = 3'd2;
   localparam logic [2:0] ST_RESP     = 3'd3;
   localparam logic [2:0] ST_DRAIN    = 3'd4;

   localparam logic UNIT_MDU = 1'b0;
   localparam logic UNIT_AVA = 1'b1;

   function automatic logic [2:0] busy_state(input logic unit);
      return (unit == UNIT_MDU) ? ST_BUSY_MDU : ST_BUSY_AVA;
   endfunction

endpackage

// File: rtl/serv_ext_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once the count has reached TIMEOUT. TIMEOUT=0 disables it.
module serv_ext_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   // Saturates at LIMIT so a long stall cannot wrap back below the threshold.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && (cnt != LIMIT))
         cnt <= cnt + 1'b1;
   end

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         assign expired = en && (cnt == LIMIT);
      end
   endgenerate

endmodule

// File: rtl/serv_ext_arbiter.sv
// Sequences the SERV extension port between the MDU and the AVA accelerator,
// one request at a time, with a watchdog that force-completes hung requests.
module serv_ext_arbiter
   import serv_ext_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_mdu_valid,
   input  logic        i_ava_valid,
   input  logic [31:0] i_ext_rs1,
   input  logic [31:0] i_ext_rs2,
   input  logic [2:0]  i_ext_funct3,
   output logic        o_ext_ready,
   output logic [31:0] o_ext_rd,
   output logic [31:0] o_unit_rs1,
   output logic [31:0] o_unit_rs2,
   output logic [2:0]  o_unit_funct3,
   output logic        o_mdu_valid,
   input  logic        i_mdu_ready,
   input  logic [31:0] i_mdu_rd,
   output logic        o_ava_valid,
   input  logic        i_ava_ready,
   input  logic [31:0] i_ava_rd,
   output logic        o_err
);

   logic [2:0]  state;
   logic        req_unit;
   logic        busy;
   logic        unit_ready;
   logic [31:0] unit_rd;
   logic        wd_expired;

   assign req_unit = i_mdu_valid ? UNIT_MDU : UNIT_AVA;
   assign busy     = (state == ST_BUSY_MDU) || (state == ST_BUSY_AVA);

   // Only the unit currently being served can complete the request.
   always_comb begin
      unit_ready = 1'b0;
      unit_rd    = '0;
      if (state == ST_BUSY_MDU) begin
         unit_ready = i_mdu_ready;
         unit_rd    = i_mdu_rd;
      end else if (state == ST_BUSY_AVA) begin
         unit_ready = i_ava_ready;
         unit_rd    = i_ava_rd;
      end
   end

   serv_ext_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (i_rst),
      .clr     (state == ST_IDLE),
      .en      (busy),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         o_ext_ready   <= 1'b0;
         o_ext_rd      <= '0;
         o_err         <= 1'b0;
         o_mdu_valid   <= 1'b0;
         o_ava_valid   <= 1'b0;
         o_unit_rs1    <= '0;
         o_unit_rs2    <= '0;
         o_unit_funct3 <= '0;
      end else begin
         o_ext_ready <= 1'b0;
         o_ext_rd    <= '0;
         o_err       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_mdu_valid || i_ava_valid) begin
                  o_unit_rs1    <= i_ext_rs1;
                  o_unit_rs2    <= i_ext_rs2;
                  o_unit_funct3 <= i_ext_funct3;
                  o_mdu_valid   <= (req_unit == UNIT_MDU);
                  o_ava_valid   <= (req_unit == UNIT_AVA);
                  state         <= busy_state(req_unit);
               end
            end
            ST_BUSY_MDU, ST_BUSY_AVA: begin
               // A ready arriving on the expiry cycle still delivers its data.
               if (unit_ready || wd_expired) begin
                  o_mdu_valid <= 1'b0;
                  o_ava_valid <= 1'b0;
                  o_ext_ready <= 1'b1;
                  o_ext_rd    <= unit_ready ? unit_rd : 32'd0;
                  o_err       <= !unit_ready;
                  state       <= ST_RESP;
               end
            end
            ST_RESP:  state <= ST_DRAIN;
            ST_DRAIN: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule
